// File: rtl/fft_ctrl_param_pkg.sv
// Shared definitions for the FFT controller.
//   fft_state_e : controller states
//   bank_aw()   : word-address width of one memory bank for a 2^log2n point transform
//   stage_w()   : width of the butterfly stage counter
//   parity()    : bank selector for a point index (XOR of all its bits)
//   bitrev()    : reverse the low 'width' bits of a value
package fft_ctrl_param_pkg;

    localparam int MAX_LOG2N = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_UNLOAD
    } fft_state_e;

    // Two banks, each holding half of the points.
    function automatic int bank_aw(input int log2n);
        return log2n - 1;
    endfunction

    function automatic int stage_w(input int log2n);
        return (log2n <= 2) ? 1 : $clog2(log2n);
    endfunction

    // Butterfly partners differ in exactly one bit, so XOR parity always
    // places them in opposite banks.
    function automatic logic parity(input logic [MAX_LOG2N-1:0] a);
        return ^a;
    endfunction

    // Full-width reverse, then shift the reversed low field back down.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] a,
                                                    input int width);
        logic [MAX_LOG2N-1:0] r;
        r = {<<{a}};
        return r >> (MAX_LOG2N - width);
    endfunction

endpackage

// File: rtl/fft_ctrl_param_addr_gen.sv
// fft_addr_gen: combinational butterfly address generation.
//   stage_i  : butterfly stage s
//   k_i      : butterfly index within the stage
//   raddr0_o : word address presented to bank 0
//   raddr1_o : word address presented to bank 1
//   swap_o   : 1 when the upper operand (point i) lives in bank 1
//   tw_o     : twiddle ROM index
module fft_addr_gen
    import fft_ctrl_param_pkg::*;
#(
    parameter  int LOG2N = 6,
    localparam int BW    = bank_aw(LOG2N),
    localparam int SW    = stage_w(LOG2N)
) (
    input  logic [SW-1:0] stage_i,
    input  logic [BW-1:0] k_i,
    output logic [BW-1:0] raddr0_o,
    output logic [BW-1:0] raddr1_o,
    output logic [BW-1:0] tw_o,
    output logic          swap_o
);

    logic [LOG2N-1:0] k_ext, low_m, i_pt, j_pt;
    logic [BW-1:0]    i_word, j_word;
    logic             i_par;
    int               pos;

    always_comb begin
        // pos is the bit where a zero is inserted into k to form i.
        pos    = LOG2N - 1 - int'(stage_i);
        k_ext  = LOG2N'(k_i);
        low_m  = LOG2N'((1 << pos) - 1);
        i_pt   = ((k_ext & ~low_m) << 1) | (k_ext & low_m);
        j_pt   = i_pt | LOG2N'(1 << pos);
        i_word = BW'(i_pt >> 1);
        j_word = BW'(j_pt >> 1);
        i_par  = parity(MAX_LOG2N'(i_pt));
        raddr0_o = i_par ? j_word : i_word;
        raddr1_o = i_par ? i_word : j_word;
        swap_o   = i_par;
        // i mod (N>>(s+1)) is just the bits of k below pos.
        tw_o     = BW'((k_ext & low_m) << stage_i);
    end

endmodule

// File: rtl/fft_ctrl_param.sv
// fft_ctrl_param: control/address sequencer for an in-place radix-2 FFT
// over two single-port-per-direction memory banks.
//   clk, rst            : clock, asynchronous active-high reset
//   start, inverse      : begin a transform (IDLE only), IFFT mode latched at start
//   in_valid / in_ready : input sample handshake during LOAD
//   we_b*, waddr_b*     : bank write enables / word addresses (load and write-back)
//   re_b*, raddr_b*     : bank read enables / word addresses (compute and unload)
//   rd_swap, wr_swap    : operand bank ordering at read and at write-back
//   tw_addr, tw_conj    : twiddle ROM index and conjugate flag
//   stage               : current butterfly stage
//   out_valid, out_idx  : output sample valid and its frequency index
//   busy, done          : activity flag and one-cycle completion pulse
module fft_ctrl_param
    import fft_ctrl_param_pkg::*;
#(
    parameter  int LOG2N    = 6,
    parameter  int PIPE_LAT = 3,
    parameter  int RD_LAT   = 1,
    parameter  int REORDER  = 1,
    localparam int BW       = bank_aw(LOG2N),
    localparam int SW       = stage_w(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inverse,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             we_b0,
    output logic             we_b1,
    output logic [BW-1:0]    waddr_b0,
    output logic [BW-1:0]    waddr_b1,
    output logic             re_b0,
    output logic             re_b1,
    output logic [BW-1:0]    raddr_b0,
    output logic [BW-1:0]    raddr_b1,
    output logic             rd_swap,
    output logic             wr_swap,
    output logic [BW-1:0]    tw_addr,
    output logic             tw_conj,
    output logic [SW-1:0]    stage,
    output logic             out_valid,
    output logic [LOG2N-1:0] out_idx,
    output logic             busy,
    output logic             done
);

    localparam int N  = 1 << LOG2N;
    // One extra bit so UNLOAD can count through the read-latency tail.
    localparam int CW = LOG2N + 1;

    localparam logic [CW-1:0] LOAD_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] CMP_LAST   = CW'(N / 2 - 1);
    localparam logic [CW-1:0] DRN_LAST   = CW'(PIPE_LAT - 1);
    localparam logic [CW-1:0] UNL_LAST   = CW'(N - 1 + RD_LAT);
    localparam logic [CW-1:0] UNL_RD_END = CW'(N);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2N - 1);

    typedef struct packed {
        logic          vld;
        logic          swap;
        logic [BW-1:0] a0;
        logic [BW-1:0] a1;
    } wb_ent_t;

    typedef struct packed {
        logic             vld;
        logic             swap;
        logic [LOG2N-1:0] idx;
    } un_ent_t;

    fft_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          conj_q, conj_d;
    logic          done_q, done_d;

    logic [BW-1:0] ag_ra0, ag_ra1, ag_tw;
    logic          ag_swap;

    logic [LOG2N-1:0] m_idx, p_pt;
    logic             p_par, n_par, unl_rd;

    wb_ent_t                      wb_in, wb_out;
    wb_ent_t [PIPE_LAT-1:0]       wb_pipe_q;
    wb_ent_t [PIPE_LAT:0]         wb_sh;
    un_ent_t                      un_in, un_out;
    un_ent_t [RD_LAT-1:0]         un_pipe_q;
    un_ent_t [RD_LAT:0]           un_sh;

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .stage_i  (stage_q),
        .k_i      (cnt_q[BW-1:0]),
        .raddr0_o (ag_ra0),
        .raddr1_o (ag_ra1),
        .tw_o     (ag_tw),
        .swap_o   (ag_swap)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            conj_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            conj_q  <= conj_d;
            done_q  <= done_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        conj_d  = conj_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                    conj_d  = inverse;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (cnt_q == CMP_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Let the last write-back of the stage land before the next stage reads.
                if (cnt_q == DRN_LAST) begin
                    cnt_d = '0;
                    if (stage_q == STAGE_LAST) begin
                        state_d = ST_UNLOAD;
                    end else begin
                        state_d = ST_COMPUTE;
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (cnt_q == UNL_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase
    end

    // ---------------- load / unload addressing ----------------
    always_comb begin
        m_idx  = cnt_q[LOG2N-1:0];
        p_pt   = (REORDER != 0) ? LOG2N'(bitrev(MAX_LOG2N'(m_idx), LOG2N)) : m_idx;
        p_par  = parity(MAX_LOG2N'(p_pt));
        n_par  = parity(MAX_LOG2N'(m_idx));
        unl_rd = (state_q == ST_UNLOAD) && (cnt_q < UNL_RD_END);
    end

    // ---------------- delay lines ----------------
    always_comb begin
        wb_in      = '0;
        wb_in.vld  = (state_q == ST_COMPUTE);
        if (wb_in.vld) begin
            wb_in.swap = ag_swap;
            wb_in.a0   = ag_ra0;
            wb_in.a1   = ag_ra1;
        end
        un_in      = '0;
        un_in.vld  = unl_rd;
        if (unl_rd) begin
            un_in.swap = p_par;
            un_in.idx  = m_idx;
        end
        // Shifting through a one-wider vector keeps PIPE_LAT/RD_LAT = 1 legal.
        wb_sh  = {wb_pipe_q, wb_in};
        un_sh  = {un_pipe_q, un_in};
        wb_out = wb_pipe_q[PIPE_LAT-1];
        un_out = un_pipe_q[RD_LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_pipe_q <= '0;
            un_pipe_q <= '0;
        end else begin
            wb_pipe_q <= wb_sh[PIPE_LAT-1:0];
            un_pipe_q <= un_sh[RD_LAT-1:0];
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready = (state_q == ST_LOAD);
        busy     = (state_q != ST_IDLE);
        we_b0    = wb_out.vld;
        we_b1    = wb_out.vld;
        waddr_b0 = wb_out.a0;
        waddr_b1 = wb_out.a1;
        re_b0    = 1'b0;
        re_b1    = 1'b0;
        raddr_b0 = '0;
        raddr_b1 = '0;
        rd_swap  = 1'b0;
        tw_addr  = '0;
        case (state_q)
            ST_LOAD: begin
                // Write-back pipe is empty here, so load owns the write ports.
                if (in_valid) begin
                    we_b0    = ~n_par;
                    we_b1    = n_par;
                    waddr_b0 = m_idx[LOG2N-1:1];
                    waddr_b1 = m_idx[LOG2N-1:1];
                end
            end
            ST_COMPUTE: begin
                re_b0    = 1'b1;
                re_b1    = 1'b1;
                raddr_b0 = ag_ra0;
                raddr_b1 = ag_ra1;
                rd_swap  = ag_swap;
                tw_addr  = ag_tw;
            end
            ST_UNLOAD: begin
                if (unl_rd) begin
                    re_b0 = ~p_par;
                    re_b1 = p_par;
                    if (p_par) raddr_b1 = p_pt[LOG2N-1:1];
                    else       raddr_b0 = p_pt[LOG2N-1:1];
                end
                // Bank select travels with the read data.
                rd_swap = un_out.swap;
            end
            default: ;
        endcase
    end

    assign wr_swap   = wb_out.swap;
    assign out_valid = un_out.vld;
    assign out_idx   = un_out.idx;
    assign tw_conj   = conj_q;
    assign stage     = stage_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fft_ctrl_param.sv
// Directed bench for fft_ctrl_param at LOG2N=3, PIPE_LAT=3, RD_LAT=1, REORDER=1.
module tb_fft_ctrl_param;

    localparam int LOG2N    = 3;
    localparam int PIPE_LAT = 3;
    localparam int RD_LAT   = 1;
    localparam int BW       = 2;
    localparam int SW       = 2;
    localparam int MAXC     = 60;

    logic             clk = 1'b0;
    logic             rst, start, inverse, in_valid;
    logic             in_ready, we_b0, we_b1, re_b0, re_b1;
    logic [BW-1:0]    waddr_b0, waddr_b1, raddr_b0, raddr_b1, tw_addr;
    logic             rd_swap, wr_swap, tw_conj, out_valid, busy, done;
    logic [SW-1:0]    stage;
    logic [LOG2N-1:0] out_idx;

    fft_ctrl_param #(.LOG2N(LOG2N), .PIPE_LAT(PIPE_LAT), .RD_LAT(RD_LAT), .REORDER(1)) dut (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse), .in_valid(in_valid),
        .in_ready(in_ready), .we_b0(we_b0), .we_b1(we_b1),
        .waddr_b0(waddr_b0), .waddr_b1(waddr_b1), .re_b0(re_b0), .re_b1(re_b1),
        .raddr_b0(raddr_b0), .raddr_b1(raddr_b1), .rd_swap(rd_swap), .wr_swap(wr_swap),
        .tw_addr(tw_addr), .tw_conj(tw_conj), .stage(stage), .out_valid(out_valid),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-cycle trace of one transform, cycle 0 = first cycle in LOAD.
    int busy_t [MAXC], rdy_t [MAXC], conj_t [MAXC], done_t [MAXC];
    int we0_t [MAXC], we1_t [MAXC], wa0_t [MAXC], wa1_t [MAXC], wsw_t [MAXC];
    int re0_t [MAXC], re1_t [MAXC], ra0_t [MAXC], ra1_t [MAXC], rsw_t [MAXC];
    int tw_t [MAXC], stg_t [MAXC], ov_t [MAXC], oi_t [MAXC];

    int exp_p   [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int exp_par [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

    // mode 0: in_valid always high; mode 1: in_valid toggles 1,0,...
    // start is re-asserted mid-transform to confirm it is ignored.
    task automatic run(input int mode, input logic inv);
        @(negedge clk);
        start = 1'b1; inverse = inv; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; inverse = ~inv;
        for (int c = 0; c < MAXC; c++) begin
            in_valid = (mode == 1) ? ((c % 2) == 0) : 1'b1;
            start    = (c >= 20 && c <= 22);
            #1;
            busy_t[c] = busy;     rdy_t[c] = in_ready; conj_t[c] = tw_conj; done_t[c] = done;
            we0_t[c]  = we_b0;    we1_t[c] = we_b1;    wa0_t[c] = waddr_b0; wa1_t[c] = waddr_b1;
            wsw_t[c]  = wr_swap;  re0_t[c] = re_b0;    re1_t[c] = re_b1;
            ra0_t[c]  = raddr_b0; ra1_t[c] = raddr_b1; rsw_t[c] = rd_swap;
            tw_t[c]   = tw_addr;  stg_t[c] = stage;    ov_t[c] = out_valid; oi_t[c] = out_idx;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    function automatic int sum_of(input int a [MAXC], input int lo, input int hi);
        int s = 0;
        for (int c = lo; c <= hi; c++) s += a[c];
        return s;
    endfunction

    initial begin
        int cnt;
        rst = 1'b1; start = 1'b0; inverse = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we", {we_b0, we_b1, re_b0, re_b1}, 0);
        chk("rst_addr", {waddr_b0, waddr_b1, raddr_b0, raddr_b1, tw_addr}, 0);
        chk("rst_misc", {stage, rd_swap, wr_swap, out_valid, done, tw_conj}, 0);
        rst = 1'b0;

        // ---- full transform, in_valid always high, IFFT ----
        run(0, 1'b1);
        chk("n_busy_cycles", sum_of(busy_t, 0, MAXC-1), 38);
        chk("n_done", sum_of(done_t, 0, MAXC-1), 1);
        chk("done_cycle", done_t[38], 1);
        chk("conj_latched", conj_t[0], 1);
        chk("in_ready_load", rdy_t[0], 1);
        chk("in_ready_cmp", rdy_t[8], 0);
        chk("load_writes", sum_of(we0_t, 0, 7) + sum_of(we1_t, 0, 7), 8);
        chk("total_writes", sum_of(we0_t, 0, MAXC-1) + sum_of(we1_t, 0, MAXC-1), 32);
        // stage 0
        chk("s0k0_re", {re0_t[8][0], re1_t[8][0]}, 3);
        chk("s0k0_ra0", ra0_t[8], 0);
        chk("s0k0_ra1", ra1_t[8], 2);
        chk("s0k0_swap", rsw_t[8], 0);
        chk("s0k0_tw", tw_t[8], 0);
        chk("s0k1_ra0", ra0_t[9], 2);
        chk("s0k1_ra1", ra1_t[9], 0);
        chk("s0k1_swap", rsw_t[9], 1);
        chk("s0k1_tw", tw_t[9], 1);
        chk("s0k0_wb_we", we0_t[11] + we1_t[11], 2);
        chk("s0k0_wb_addr", wa0_t[11] * 4 + wa1_t[11], 2);
        chk("s0k1_wb_addr", wa0_t[12] * 4 + wa1_t[12], 8);
        chk("s0k1_wb_swap", wsw_t[12], 1);
        chk("drain_no_read", re0_t[12] + re1_t[13] + re0_t[14], 0);
        // stage 1
        chk("s1_stage", stg_t[15], 1);
        chk("s1k1_addr", ra0_t[16] * 4 + ra1_t[16], 4);
        chk("s1k1_swap_tw", rsw_t[16] * 4 + tw_t[16], 6);
        chk("s1k2_addr", ra0_t[17] * 4 + ra1_t[17], 14);
        chk("s1k2_tw", tw_t[17], 0);
        // stage 2
        chk("s2_stage", stg_t[22], 2);
        chk("s2k0_addr", ra0_t[22] * 4 + ra1_t[22], 0);
        chk("s2k0_swap", rsw_t[22], 0);
        chk("s2k1_addr_swap", ra0_t[23] * 8 + ra1_t[23] * 2 + rsw_t[23], 11);
        chk("s2k0_wb_early", we0_t[24] + we1_t[24], 0);
        chk("s2k0_wb_we", we0_t[25] + we1_t[25], 2);
        chk("s2k0_wb_addr", wa0_t[25] * 4 + wa1_t[25], 0);
        // unload
        chk("unl_first_ov", ov_t[29], 0);
        chk("unl_after_ov", ov_t[38], 0);
        for (int m = 0; m < 8; m++) begin
            chk($sformatf("unl_re1_m%0d", m), re1_t[29+m], exp_par[m]);
            chk($sformatf("unl_re0_m%0d", m), re0_t[29+m], 1 - exp_par[m]);
            chk($sformatf("unl_word_m%0d", m),
                (exp_par[m] == 1) ? ra1_t[29+m] : ra0_t[29+m], exp_p[m] / 2);
            chk($sformatf("unl_ov_m%0d", m), ov_t[30+m], 1);
            chk($sformatf("unl_idx_m%0d", m), oi_t[30+m], m);
            chk($sformatf("unl_swap_m%0d", m), rsw_t[30+m], exp_par[m]);
        end

        // ---- stalled load, FFT ----
        run(1, 1'b0);
        chk("tg_conj", conj_t[0], 0);
        chk("tg_load_writes", sum_of(we0_t, 0, 14) + sum_of(we1_t, 0, 14), 8);
        cnt = 0;
        for (int c = 1; c < 15; c += 2) cnt += we0_t[c] + we1_t[c];
        chk("tg_stall_no_we", cnt, 0);
        chk("tg_s5_bank", we0_t[10] * 2 + we1_t[10], 2);
        chk("tg_s5_word", wa0_t[10], 2);
        chk("tg_n_busy", sum_of(busy_t, 0, MAXC-1), 45);
        chk("tg_done_cycle", done_t[45], 1);
        chk("tg_n_done", sum_of(done_t, 0, MAXC-1), 1);

        // ---- reset in COMPUTE with write-backs pending ----
        @(negedge clk);
        start = 1'b1; inverse = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("pre_rst_cmp", {busy, re_b0, re_b1}, 7);
        #1 rst = 1'b1;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_enables", {we_b0, we_b1, re_b0, re_b1, out_valid, in_ready}, 0);
        chk("ar_addr", {waddr_b0, waddr_b1, raddr_b0, raddr_b1, tw_addr, stage}, 0);
        chk("ar_conj_swaps", {tw_conj, rd_swap, wr_swap}, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            cnt += int'(we_b0) + int'(we_b1) + int'(busy) + int'(done);
            @(negedge clk);
        end
        chk("post_rst_quiet", cnt, 0);

        run(0, 1'b0);
        chk("restart_busy", sum_of(busy_t, 0, MAXC-1), 38);
        chk("restart_done", done_t[38], 1);
        chk("restart_writes", sum_of(we0_t, 0, MAXC-1) + sum_of(we1_t, 0, MAXC-1), 32);
        chk("restart_s0k0", ra0_t[8] * 4 + ra1_t[8], 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fft_ctrl_param.md
FFT_CTRL_PARAM -- requirements
Module: fft_ctrl_param

Interface
REQ-001 SHALL have parameter LOG2N, default 6, meaning log2 of transform points N; legal range 3..10.
REQ-002 SHALL have parameter PIPE_LAT, default 3, meaning cycles from read-address issue to butterfly result write-back; legal range 1..8.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning memory read latency in cycles; legal range 1..2.
REQ-004 SHALL have parameter REORDER, default 1, meaning 1 = natural-order unload, 0 = bit-reversed unload.
REQ-005 SHALL have ports (name direction width meaning), one per line:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a transform; honoured in IDLE only
inverse  in  1  IFFT mode, sampled at start
in_valid  in  1  input sample present during LOAD
in_ready  out  1  high in LOAD
we_b0, we_b1  out  1  bank write enables
waddr_b0, waddr_b1  out  LOG2N-1  bank write word addresses
re_b0, re_b1  out  1  bank read enables
raddr_b0, raddr_b1  out  LOG2N-1  bank read word addresses
rd_swap  out  1  1 = upper butterfly operand is in bank 1
wr_swap  out  1  rd_swap delayed PIPE_LAT cycles
tw_addr  out  LOG2N-1  twiddle ROM index
tw_conj  out  1  conjugate twiddle (= latched inverse)
stage  out  ceil(log2(LOG2N))  current butterfly stage
out_valid  out  1  output sample valid
out_idx  out  LOG2N  frequency index of the output sample
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after the last output

Function
REQ-006 Address mapping: point a (LOG2N bits) SHALL reside in bank parity(a), at word a>>1.
REQ-007 FSM states SHALL be IDLE, LOAD, COMPUTE, DRAIN, UNLOAD.
REQ-008 IDLE->LOAD on start; inverse latched into tw_conj on the same edge.
REQ-009 LOAD: each cycle with in_valid, sample n (0..N-1) SHALL be written with we_b[parity(n)]=1 at word n>>1; after sample N-1 -> COMPUTE with stage=0.
REQ-010 COMPUTE stage s, butterfly k=0..N/2-1, one per cycle: i = k with a 0 inserted at bit LOG2N-1-s; j = i | (N>>(s+1)).
REQ-011 Per butterfly, both re_b0 and re_b1 SHALL be 1; the bank holding i SHALL get word i>>1 and the other bank word j>>1; rd_swap = parity(i); tw_addr = (i mod (N>>(s+1))) << s.
REQ-012 Write-back: raddr_b0/b1, rd_swap and the compute-active flag SHALL be delayed exactly PIPE_LAT cycles to drive waddr_b0/b1, wr_swap and we_b0/we_b1 (both banks).
REQ-013 After k=N/2-1 -> DRAIN for exactly PIPE_LAT cycles with no reads; then stage+1 -> COMPUTE, or after stage LOG2N-1 -> UNLOAD.
REQ-014 UNLOAD: m=0..N-1, one per cycle; address p = bitrev(m) if REORDER=1, else p = m; read bank parity(p) at word p>>1; out_valid and out_idx=m SHALL follow RD_LAT cycles later, with rd_swap=parity(p) aligned to the data.
REQ-015 done SHALL pulse one cycle after the last out_valid; FSM SHALL return to IDLE on the same edge.
REQ-016 start outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-017 Counters SHALL wrap only at their terminal counts; no write SHALL occur outside LOAD or delayed write-back.

Reset
REQ-018 rst SHALL asynchronously force IDLE and clear all counters and delay lines; all enables, valids, done, busy and in_ready SHALL be 0, and addresses, swaps, tw_addr and stage SHALL be 0.
REQ-019 rst asserted mid-transform SHALL abort it: no pending write-back may complete after rst deasserts.

Structure
REQ-020 A shared package SHALL hold the state enum, the parity and bitrev functions, and the bank-address width formula.
REQ-021 One sub-module, fft_addr_gen (combinational i/j/tw/bank generation from stage and k), SHALL be instantiated.

Verification
REQ-022 LOG2N=3, PIPE_LAT=3: stage 0, k=0 -> raddr_b0=0, raddr_b1=2, rd_swap=0, tw_addr=0; k=1 -> raddr_b0=2, raddr_b1=0, rd_swap=1, tw_addr=1.
REQ-023 LOG2N=3: stage 2, k=0 -> raddr_b0=0, raddr_b1=0, rd_swap=0; matching we_b0=we_b1=1 exactly 3 cycles later with waddr=0.
REQ-024 LOG2N=3, PIPE_LAT=3, in_valid always high: busy lasts 8 (load) + 21 (compute/drain) + 8 + RD_LAT (unload) cycles; done pulses once.
REQ-025 in_valid toggling 1,0 during LOAD -> exactly 8 writes; stall cycles produce no we; sample 5 -> we_b0 at word 2.
REQ-026 REORDER=1, LOG2N=3: out_idx = 0..7, read points 0,4,2,6,1,5,3,7; rst pulsed in COMPUTE -> outputs zero immediately, no we after release, start restarts cleanly.
